// File: rtl/axi_mem_responder_pkg.sv
// Shared definitions for the AXI memory responder: response codes, FSM
// encodings and the address-window decode helper.
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ADDR = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

    // Widened to 64 bits so base+size cannot overflow at the top of the address map.
    function automatic logic addr_in_window(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input logic [63:0] size);
        return (addr >= base) && (addr < (base + size));
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word array backing the responder: one byte-enabled write port and one
// registered read port (a read of a word being written returns the old data).
module axi_mem_array #(
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we && wstrb[i]) begin
                mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave stand-in for the 128-bit DDR-controller port: init delay, range
// decode and independent write/read burst FSMs over an on-chip word array.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_LOG2  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8f000000,
    parameter int                INIT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic                mem_ready
);

    localparam int          STRB_W    = DATA_W / 8;
    localparam int          OFF_W     = $clog2(STRB_W);
    localparam int          CNT_W     = $clog2(INIT_CYCLES + 1);
    localparam logic [63:0] MEM_BYTES = 64'(STRB_W) << DEPTH_LOG2;

    logic [CNT_W-1:0]      init_cnt_r;
    logic                  mem_ready_r;

    wr_state_t             wr_state_r;
    logic [DEPTH_LOG2-1:0] wr_idx_r;
    logic [7:0]            wr_len_r;
    logic [7:0]            wr_cnt_r;
    logic                  wr_err_r;
    logic                  wr_last_err_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;

    rd_state_t             rd_state_r;
    logic [DEPTH_LOG2-1:0] rd_idx_r;
    logic [7:0]            rd_len_r;
    logic [7:0]            rd_cnt_r;
    logic                  rd_err_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [1:0]            rresp_r;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, r_hs_s;
    logic                  aw_in_range_s, ar_in_range_s;
    logic                  wr_final_s, rd_final_s, wlast_bad_s;
    logic                  mem_we_s, mem_re_s;
    logic [DEPTH_LOG2-1:0] mem_raddr_s;
    logic [DATA_W-1:0]     mem_rdata_s;

    assign aw_hs_s       = awvalid & awready_r;
    assign w_hs_s        = wvalid & wready_r;
    assign ar_hs_s       = arvalid & arready_r;
    assign r_hs_s        = rvalid_r & rready;
    assign aw_in_range_s = addr_in_window(64'(awaddr), 64'(BASE_ADDR), MEM_BYTES);
    assign ar_in_range_s = addr_in_window(64'(araddr), 64'(BASE_ADDR), MEM_BYTES);
    assign wr_final_s    = (wr_cnt_r == wr_len_r);
    assign rd_final_s    = (rd_cnt_r == rd_len_r);
    assign wlast_bad_s   = wlast ^ wr_final_s;
    assign mem_we_s      = w_hs_s & ~wr_err_r;

    // Calibration stand-in: mem_ready rises INIT_CYCLES clocks after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_cnt_r  <= '0;
            mem_ready_r <= 1'b0;
        end else if (!mem_ready_r) begin
            init_cnt_r <= init_cnt_r + CNT_W'(1);
            if (init_cnt_r == CNT_W'(INIT_CYCLES - 1)) begin
                mem_ready_r <= 1'b1;
            end
        end
    end

    // Write FSM: one burst outstanding; out-of-range bursts are consumed but not stored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_r    <= W_IDLE;
            wr_idx_r      <= '0;
            wr_len_r      <= 8'd0;
            wr_cnt_r      <= 8'd0;
            wr_err_r      <= 1'b0;
            wr_last_err_r <= 1'b0;
            awready_r     <= 1'b0;
            wready_r      <= 1'b0;
            bvalid_r      <= 1'b0;
            bresp_r       <= RESP_OKAY;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awready_r     <= 1'b0;
                        wready_r      <= 1'b1;
                        wr_idx_r      <= awaddr[OFF_W +: DEPTH_LOG2];
                        wr_len_r      <= awlen;
                        wr_cnt_r      <= 8'd0;
                        wr_err_r      <= ~aw_in_range_s;
                        wr_last_err_r <= 1'b0;
                        wr_state_r    <= W_DATA;
                    end else begin
                        awready_r <= mem_ready_r;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        wr_idx_r <= wr_idx_r + DEPTH_LOG2'(1);
                        wr_cnt_r <= wr_cnt_r + 8'd1;
                        if (wr_final_s) begin
                            wready_r   <= 1'b0;
                            bvalid_r   <= 1'b1;
                            bresp_r    <= (wr_err_r | wr_last_err_r | wlast_bad_s) ?
                                          RESP_SLVERR : RESP_OKAY;
                            wr_state_r <= W_RESP;
                        end else begin
                            wr_last_err_r <= wr_last_err_r | wlast_bad_s;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_r && bready) begin
                        bvalid_r   <= 1'b0;
                        bresp_r    <= RESP_OKAY;
                        awready_r  <= mem_ready_r;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r  <= 1'b0;
                    wready_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read port steering: prime the first word in R_ADDR, prefetch the next on each beat.
    always_comb begin
        mem_re_s    = 1'b0;
        mem_raddr_s = rd_idx_r;
        if (rd_state_r == R_ADDR) begin
            mem_re_s = 1'b1;
        end else if ((rd_state_r == R_DATA) && r_hs_s && !rd_final_s) begin
            mem_re_s    = 1'b1;
            mem_raddr_s = rd_idx_r + DEPTH_LOG2'(1);
        end else begin
            mem_re_s = 1'b0;
        end
    end

    // Read FSM: R beats held stable until rready; counter and index advance per beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_r <= R_IDLE;
            rd_idx_r   <= '0;
            rd_len_r   <= 8'd0;
            rd_cnt_r   <= 8'd0;
            rd_err_r   <= 1'b0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        arready_r  <= 1'b0;
                        rd_idx_r   <= araddr[OFF_W +: DEPTH_LOG2];
                        rd_len_r   <= arlen;
                        rd_cnt_r   <= 8'd0;
                        rd_err_r   <= ~ar_in_range_s;
                        rd_state_r <= R_ADDR;
                    end else begin
                        arready_r <= mem_ready_r;
                    end
                end
                R_ADDR: begin
                    rvalid_r   <= 1'b1;
                    rlast_r    <= (rd_len_r == 8'd0);
                    rresp_r    <= rd_err_r ? RESP_SLVERR : RESP_OKAY;
                    rd_state_r <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        if (rd_final_s) begin
                            rvalid_r   <= 1'b0;
                            rlast_r    <= 1'b0;
                            rresp_r    <= RESP_OKAY;
                            arready_r  <= mem_ready_r;
                            rd_state_r <= R_IDLE;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + 8'd1;
                            rd_idx_r <= rd_idx_r + DEPTH_LOG2'(1);
                            rlast_r  <= ((rd_cnt_r + 8'd1) == rd_len_r);
                        end
                    end
                end
                default: begin
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    rlast_r    <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    axi_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rstn  (rstn),
        .we    (mem_we_s),
        .waddr (wr_idx_r),
        .wdata (wdata),
        .wstrb (wstrb),
        .re    (mem_re_s),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

    assign awready   = awready_r;
    assign wready    = wready_r;
    assign bvalid    = bvalid_r;
    assign bresp     = bresp_r;
    assign arready   = arready_r;
    assign rvalid    = rvalid_r;
    assign rlast     = rlast_r;
    assign rresp     = rresp_r;
    assign rdata     = rd_err_r ? '0 : mem_rdata_s;
    assign mem_ready = mem_ready_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: init delay, single and burst transfers,
// rready back-pressure, range and wlast errors, and reset in the middle of a read.
module tb_axi_mem_responder;

    localparam int          LIMIT  = 100;
    localparam logic [127:0] FULL  = {128{1'b1}};
    localparam logic [127:0] MASK16 = 128'hffff;

    logic         clk;
    logic         rstn;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    axi_mem_responder dut (
        .clk       (clk),
        .rstn      (rstn),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_ready (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        awaddr  = addr;
        awlen   = len;
        awvalid = 1'b1;
        while (awready !== 1'b1 && n < LIMIT) begin step(); n++; end
        check("aw_wait", 128'(n < LIMIT), 128'd1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n = 0;
        wdata  = data;
        wstrb  = strb;
        wlast  = last;
        wvalid = 1'b1;
        while (wready !== 1'b1 && n < LIMIT) begin step(); n++; end
        check("w_wait", 128'(n < LIMIT), 128'd1);
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp_resp);
        int n = 0;
        bready = 1'b1;
        while (bvalid !== 1'b1 && n < LIMIT) begin step(); n++; end
        check({tag, "_bwait"}, 128'(n < LIMIT), 128'd1);
        check({tag, "_bresp"}, 128'(bresp), 128'(exp_resp));
        step();
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        araddr  = addr;
        arlen   = len;
        arvalid = 1'b1;
        while (arready !== 1'b1 && n < LIMIT) begin step(); n++; end
        check("ar_wait", 128'(n < LIMIT), 128'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic [127:0] exp_data, input logic [127:0] mask,
                           input logic [1:0] exp_resp, input logic exp_last);
        int n = 0;
        rready = 1'b1;
        while (rvalid !== 1'b1 && n < LIMIT) begin step(); n++; end
        check({tag, "_rwait"}, 128'(n < LIMIT), 128'd1);
        check({tag, "_rdata"}, rdata & mask, exp_data);
        check({tag, "_rresp"}, 128'(rresp), 128'(exp_resp));
        check({tag, "_rlast"}, 128'(rlast), 128'(exp_last));
        step();
        rready = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        awaddr  = 32'h0;
        awlen   = 8'd0;
        awvalid = 1'b0;
        wdata   = 128'h0;
        wstrb   = 16'h0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = 32'h0;
        arlen   = 8'd0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_mem_ready", 128'(mem_ready), 128'd0);
        check("rst_awready", 128'(awready), 128'd0);
        check("rst_arready", 128'(arready), 128'd0);
        check("rst_bvalid", 128'(bvalid), 128'd0);
        check("rst_rvalid", 128'(rvalid), 128'd0);

        // Init delay: low for 15 edges after release, high on the 16th
        rstn = 1'b1;
        repeat (15) step();
        check("init_mem_ready_low", 128'(mem_ready), 128'd0);
        check("init_awready_low", 128'(awready), 128'd0);
        check("init_arready_low", 128'(arready), 128'd0);
        step();
        check("init_mem_ready_high", 128'(mem_ready), 128'd1);

        // W before AW is not accepted
        wdata  = 128'h5678;
        wstrb  = 16'h0003;
        wlast  = 1'b1;
        wvalid = 1'b1;
        repeat (3) step();
        check("w_before_aw", 128'(wready), 128'd0);

        // Single-beat write, then read back
        do_aw(32'h8f000004, 8'd0);
        do_w(128'h5678, 16'h0003, 1'b1);
        wait_b("single_wr", 2'b00);
        do_ar(32'h8f000004, 8'd0);
        check("rvalid_latency_0", 128'(rvalid), 128'd0);
        step();
        check("rvalid_latency_1", 128'(rvalid), 128'd1);
        rd_beat("single_rd", 128'h5678, MASK16, 2'b00, 1'b1);

        // Burst write len3 at 0x8f000100 with data 1..4
        do_aw(32'h8f000100, 8'd3);
        for (int i = 0; i < 4; i++) do_w(128'(i + 1), 16'hffff, i == 3);
        wait_b("burst_wr", 2'b00);

        // Burst read with rready toggling
        do_ar(32'h8f000100, 8'd3);
        step();
        for (int i = 0; i < 4; i++) begin
            check("burst_rvalid", 128'(rvalid), 128'd1);
            check("burst_rdata", rdata, 128'(i + 1));
            check("burst_rlast", 128'(rlast), 128'(i == 3));
            rready = 1'b0;
            step();
            check("burst_hold_rdata", rdata, 128'(i + 1));
            check("burst_hold_rlast", 128'(rlast), 128'(i == 3));
            rready = 1'b1;
            step();
            rready = 1'b0;
        end
        check("burst_rvalid_end", 128'(rvalid), 128'd0);

        // Out-of-range write and read
        do_aw(32'h90000000, 8'd1);
        do_w(128'hdead, 16'hffff, 1'b0);
        do_w(128'hbeef, 16'hffff, 1'b1);
        wait_b("oor_wr", 2'b10);
        do_ar(32'h90000000, 8'd1);
        rd_beat("oor_rd0", 128'h0, FULL, 2'b10, 1'b0);
        rd_beat("oor_rd1", 128'h0, FULL, 2'b10, 1'b1);

        // Early wlast -> SLVERR, data still stored
        do_aw(32'h8f000200, 8'd1);
        do_w(128'haaaa, 16'hffff, 1'b1);
        do_w(128'hbbbb, 16'hffff, 1'b0);
        wait_b("wlast_err_wr", 2'b10);
        do_ar(32'h8f000200, 8'd1);
        rd_beat("wlast_err_rd0", 128'haaaa, FULL, 2'b00, 1'b0);
        rd_beat("wlast_err_rd1", 128'hbbbb, FULL, 2'b00, 1'b1);

        // Reset in the middle of a read burst
        do_ar(32'h8f000100, 8'd3);
        rd_beat("mid_rd0", 128'd1, FULL, 2'b00, 1'b0);
        rstn = 1'b0;
        #1;
        check("midrst_rvalid", 128'(rvalid), 128'd0);
        check("midrst_mem_ready", 128'(mem_ready), 128'd0);
        repeat (2) step();
        rstn = 1'b1;
        do_ar(32'h8f000110, 8'd0);
        rd_beat("post_rst_rd", 128'd2, FULL, 2'b00, 1'b1);
        do_ar(32'h8f000004, 8'd0);
        rd_beat("post_rst_word0", 128'h5678, MASK16, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
